sdp_ram_be: RTL and testbench

- Simple dual-port synchronous RAM: one write port, one read port, one clock.
- Per-byte write enables, selectable read-during-write behaviour, optional output pipeline register with a valid flag.
- Optional hardware clear of the whole array after reset.
- Generic storage primitive for FIFOs, line buffers and register files.

---
 rtl/sdp_ram_be.sv | 137 +++++++++++++
 tb/tb_sdp_ram_be.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with per-byte write enables, selectable read-during-write result,
// optional output register and an optional post-reset sweep that zeroes the array.
module sdp_ram_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned OUT_REG        = 1,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_busy,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_width_check
        $error("sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {StClear, StRun} state_e;

    localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StClear : StRun;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_go;
    logic                  rd_go;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ResetState;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = ResetState;
        endcase
    end

    assign init_busy = (state_q == StClear);
    assign wr_go     = (state_q == StRun) && wr_en;
    assign rd_go     = (state_q == StRun) && rd_en;

    // ---------------------------------------------------------------- array access
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                wr_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_word = mem[rd_addr];
        // Same-address collision forwards the merged word when new-data mode is selected
        if ((RDW_MODE != 0) && wr_go && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_go) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // ---------------------------------------------------------------- read pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_go;
            if (rd_go) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= s1_data_q;
                end
            end
        end

        assign rd_data  = out_data_q;
        assign rd_valid = out_valid_q;
    end else begin : g_no_out_reg
        assign rd_data  = s1_data_q;
        assign rd_valid = s1_valid_q;
    end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: two instances (registered/old-data and unregistered/new-data)
// share stimulus; outputs are checked against a queue-based model and hand-built vectors.
module tb_sdp_ram_be;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NB    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic          busy_a, busy_b;
    logic          va, vb;
    logic [DW-1:0] da, db;

    always #5 clk = ~clk;

    sdp_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
        .OUT_REG(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(rst), .init_busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(da), .rd_valid(va)
    );

    sdp_ram_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
        .OUT_REG(0), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst(rst), .init_busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(db), .rd_valid(vb)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain word array, clear countdown, and per-instance queues of
    // read results tagged with the edge at which they must appear.
    logic [DW-1:0] m_mem [DEPTH];
    int            busy_left;
    int            edge_no;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         q_a[$];
    pend_t         q_b[$];
    logic          exp_va, exp_vb;
    logic [DW-1:0] exp_da, exp_db;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NB-1:0] wbe;
        logic          re;
        logic [AW-1:0] ra;
        logic          eva;
        logic [DW-1:0] eda;
        logic          evb;
        logic [DW-1:0] edb;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        busy_left = DEPTH;
        q_a.delete();
        q_b.delete();
        exp_va = 1'b0;
        exp_vb = 1'b0;
        exp_da = '0;
        exp_db = '0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_w;
        logic [DW-1:0] merged;
        edge_no++;
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            old_w  = m_mem[rd_addr];
            merged = m_mem[wr_addr];
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) merged[i*8 +: 8] = wr_data[i*8 +: 8];
            end
            if (rd_en) begin
                q_a.push_back('{edge_no + 1, old_w});
                q_b.push_back('{edge_no, (wr_en && wr_addr == rd_addr) ? merged : old_w});
            end
            if (wr_en) m_mem[wr_addr] = merged;
        end
        exp_va = 1'b0;
        if (q_a.size() > 0 && q_a[0].due == edge_no) begin
            exp_va = 1'b1;
            exp_da = q_a[0].data;
            void'(q_a.pop_front());
        end
        exp_vb = 1'b0;
        if (q_b.size() > 0 && q_b[0].due == edge_no) begin
            exp_vb = 1'b1;
            exp_db = q_b[0].data;
            void'(q_b.pop_front());
        end
    endtask

    task automatic check_model();
        chk("model_init_busy_a", busy_a, busy_left > 0);
        chk("model_init_busy_b", busy_b, busy_left > 0);
        chk("model_rd_valid_a", va, exp_va);
        chk("model_rd_data_a", da, exp_da);
        chk("model_rd_valid_b", vb, exp_vb);
        chk("model_rd_data_b", db, exp_db);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NB-1:0] wbe, input logic re, input logic [AW-1:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = wbe;
        rd_en   = re;
        rd_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Asserts reset between clock edges and checks the outputs clear without an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_rd_data_a", da, '0);
        chk("async_rst_rd_valid_a", va, 1'b0);
        chk("async_rst_rd_data_b", db, '0);
        chk("async_rst_rd_valid_b", vb, 1'b0);
        chk("async_rst_init_busy_a", busy_a, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(name, n, DEPTH);
    endtask

    task automatic random_phase(input int cycles);
        logic [AW-1:0] wa;
        for (int c = 0; c < cycles; c++) begin
            wa = AW'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 1)), wa, $urandom, NB'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)));
            step();
        end
        idle();
        repeat (3) step();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
            step();
        end
        idle();
        repeat (2) step();
    endtask

    initial begin
        //           we    wa  wd            wbe   re    ra  eva  eda           evb  edb
        vecs[0]  = '{1'b1, 3, 32'hAABBCCDD, 4'hF, 1'b0, 0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 3, 32'h11223344, 4'h5, 1'b0, 0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 3, 1'b0, 32'h0,        1'b1, 32'hAA22CC44};
        vecs[3]  = '{1'b0, 0, 32'h0,        4'h0, 1'b0, 0, 1'b1, 32'hAA22CC44, 1'b0, 32'hAA22CC44};
        vecs[4]  = '{1'b0, 0, 32'h0,        4'h0, 1'b0, 0, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44};
        vecs[5]  = '{1'b1, 0, 32'h10,       4'hF, 1'b0, 0, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44};
        vecs[6]  = '{1'b1, 1, 32'h11,       4'hF, 1'b0, 0, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44};
        vecs[7]  = '{1'b1, 2, 32'h12,       4'hF, 1'b0, 0, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44};
        vecs[8]  = '{1'b1, 3, 32'h13,       4'hF, 1'b0, 0, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44};
        vecs[9]  = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 0, 1'b0, 32'hAA22CC44, 1'b1, 32'h10};
        vecs[10] = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 1, 1'b1, 32'h10,       1'b1, 32'h11};
        vecs[11] = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 2, 1'b1, 32'h11,       1'b1, 32'h12};
        vecs[12] = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 3, 1'b1, 32'h12,       1'b1, 32'h13};
        vecs[13] = '{1'b0, 0, 32'h0,        4'h0, 1'b0, 0, 1'b1, 32'h13,       1'b0, 32'h13};
        vecs[14] = '{1'b0, 0, 32'h0,        4'h0, 1'b0, 0, 1'b0, 32'h13,       1'b0, 32'h13};
        vecs[15] = '{1'b1, 7, 32'hFFFF0000, 4'hC, 1'b1, 7, 1'b0, 32'h13,       1'b1, 32'hFFFF0000};
        vecs[16] = '{1'b0, 0, 32'h0,        4'h0, 1'b0, 0, 1'b1, 32'h0,        1'b0, 32'hFFFF0000};
        vecs[17] = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 7, 1'b0, 32'h0,        1'b1, 32'hFFFF0000};
        vecs[18] = '{1'b0, 0, 32'h0,        4'h0, 1'b0, 0, 1'b1, 32'hFFFF0000, 1'b0, 32'hFFFF0000};
        vecs[19] = '{1'b1, 9, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0, 32'hFFFF0000, 1'b0, 32'hFFFF0000};
        vecs[20] = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 9, 1'b0, 32'hFFFF0000, 1'b1, 32'hDEADBEEF};
        vecs[21] = '{1'b0, 0, 32'h0,        4'h0, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};

        rst     = 1'b0;
        edge_no = 0;
        idle();
        model_reset();
        #2;
        do_reset();

        // Requests during the sweep must be ignored, including this write to address 5
        drive(1'b1, 5, 32'hCAFEF00D, 4'hF, 1'b1, 5);
        count_busy("clear_busy_cycles");
        idle();
        read_all();

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wbe, vecs[i].re, vecs[i].ra);
            step();
            chk($sformatf("vec%0d_rd_valid_a", i), va, vecs[i].eva);
            chk($sformatf("vec%0d_rd_data_a", i), da, vecs[i].eda);
            chk($sformatf("vec%0d_rd_valid_b", i), vb, vecs[i].evb);
            chk($sformatf("vec%0d_rd_data_b", i), db, vecs[i].edb);
        end

        idle();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_rd_data_a", da, 32'hDEADBEEF);
            chk("hold_rd_valid_a", va, 1'b0);
            chk("hold_rd_data_b", db, 32'hDEADBEEF);
            chk("hold_rd_valid_b", vb, 1'b0);
        end

        // Write with no lanes enabled leaves the word untouched
        drive(1'b1, 9, 32'h0, 4'h0, 1'b0, 0);
        step();
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 9);
        step();
        chk("be0_rd_valid_b", vb, 1'b1);
        chk("be0_rd_data_b", db, 32'hDEADBEEF);
        idle();
        step();
        chk("be0_rd_valid_a", va, 1'b1);
        chk("be0_rd_data_a", da, 32'hDEADBEEF);

        // Reset while a completed read is still presented
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 3);
        step();
        chk("pre_rst_rd_valid_b", vb, 1'b1);
        idle();
        do_reset();
        count_busy("second_clear_busy_cycles");

        random_phase(1500);

        do_reset();
        repeat (12) step();
        do_reset();
        count_busy("midclear_busy_cycles");
        read_all();
        random_phase(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
